// File: rtl/alu_datapath.sv
// Register-file datapath: switch synchroniser, source mux, R1-R3, 4-function ALU,
// carry/zero flags and a saturating write counter, sequenced cycle by cycle by an external FSM.
module alu_datapath #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic [2:0]       wr_reg,
    input  logic [1:0]       data_path_select,
    input  logic [WIDTH-1:0] data_path_custom,
    input  logic [1:0]       alu_op_code,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic [7:0]       write_count
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] sw_meta_q, sw_meta_d;
    logic [WIDTH-1:0] sw_sync_q, sw_sync_d;
    logic [WIDTH-1:0] r1_q, r1_d;
    logic [WIDTH-1:0] r2_q, r2_d;
    logic [WIDTH-1:0] r3_q, r3_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] write_count_q, write_count_d;

    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH:0]   sum;

    // Source mux for R1/R2; R3 is fed only by the ALU.
    always_comb begin
        mux_out = '0;
        case (data_path_select)
            2'b00:   mux_out = '0;
            2'b01:   mux_out = sw_sync_q;
            2'b10:   mux_out = r3_q;
            default: mux_out = data_path_custom;
        endcase
    end

    // ALU with A = R1, B = R2; carry only meaningful for add.
    always_comb begin
        sum       = (WIDTH+1)'(r1_q) + (WIDTH+1)'(r2_q);
        alu_res   = '0;
        alu_carry = 1'b0;
        case (alu_op_code)
            2'b00: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            2'b01:   alu_res = r1_q ^ r2_q;
            2'b10:   alu_res = r1_q | r2_q;
            default: alu_res = ~r1_q;
        endcase
    end

    // Next-state: all registers sample pre-edge values, so simultaneous writes are safe.
    always_comb begin
        sw_meta_d     = sw;
        sw_sync_d     = sw_meta_q;
        r1_d          = r1_q;
        r2_d          = r2_q;
        r3_d          = r3_q;
        carry_d       = carry_q;
        zero_d        = zero_q;
        write_count_d = write_count_q;

        if (wr_reg[0]) r1_d = mux_out;
        if (wr_reg[1]) r2_d = mux_out;
        if (wr_reg[2]) begin
            r3_d    = alu_res;
            carry_d = alu_carry;
            zero_d  = (alu_res == '0);
        end
        if ((wr_reg != 3'b000) && (write_count_q != CNT_MAX)) begin
            write_count_d = write_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_q     <= '0;
            sw_sync_q     <= '0;
            r1_q          <= '0;
            r2_q          <= '0;
            r3_q          <= '0;
            carry_q       <= 1'b0;
            zero_q        <= 1'b1;
            write_count_q <= '0;
        end else begin
            sw_meta_q     <= sw_meta_d;
            sw_sync_q     <= sw_sync_d;
            r1_q          <= r1_d;
            r2_q          <= r2_d;
            r3_q          <= r3_d;
            carry_q       <= carry_d;
            zero_q        <= zero_d;
            write_count_q <= write_count_d;
        end
    end

    assign r1          = r1_q;
    assign r2          = r2_q;
    assign r3          = r3_q;
    assign alu_out     = alu_res;
    assign carry_flag  = carry_q;
    assign zero_flag   = zero_q;
    assign write_count = write_count_q;

endmodule
